// File: rtl/mtl2_lcd_timing_gen_pkg.sv
// Shared definitions for the MTL2 LCD timing generator.
//   - default MTL2 800x480 timing constants
//   - lock FSM state encoding
//   - raster counter width and a saturating increment helper
package mtl2_lcd_timing_gen_pkg;
  localparam int CW = 12;  // raster counter width; all totals < 4096

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 210;
  localparam int DEF_H_SYNC   = 30;
  localparam int DEF_H_BP     = 16;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 22;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 20;

  typedef enum logic {
    STATE_SEEK   = 1'b0,
    STATE_LOCKED = 1'b1
  } lock_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
endpackage

// File: rtl/mtl2_lcd_timing_gen_if.sv
// Pixel stream from the frame reader: 24-bit {R,G,B} beats with a
// start-of-frame marker and valid/ready handshake.
//   master: frame reader side (drives data/sof/valid)
//   slave : timing generator side (drives ready)
interface mtl2_lcd_timing_gen_if;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, pix_sof, pix_valid, input  pix_ready);
  modport slave  (input  pix_data, pix_sof, pix_valid, output pix_ready);
endinterface

// File: rtl/mtl2_raster_counter.sv
// Free-running h/v raster counters with combinational position decodes.
//   iCLK, iRST : pixel clock, async active-high reset
//   active     : h < H_ACTIVE && v < V_ACTIVE
//   hsync_n    : low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//   vsync_n    : low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
//   origin     : h == 0 && v == 0 (first active pixel of a frame)
module mtl2_raster_counter
  import mtl2_lcd_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic iCLK,
  input  logic iRST,
  output logic active,
  output logic hsync_n,
  output logic vsync_n,
  output logic origin
);
  localparam logic [CW-1:0] HT  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [CW-1:0] VT  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h, v;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      h <= '0;
      v <= '0;
    end else if (h == HT - 1'b1) begin
      h <= '0;
      v <= (v == VT - 1'b1) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign active  = (h < HA) && (v < VA);
  assign hsync_n = !((h >= HS0) && (h < HS1));
  assign vsync_n = !((v >= VS0) && (v < VS1));
  assign origin  = (h == '0) && (v == '0);
endmodule

// File: rtl/mtl2_lcd_timing_gen.sv
// MTL2 LCD timing generator and pixel sink (pixel clock domain).
// Locks an incoming SOF-marked pixel stream to the raster origin, blanks
// starved pixels, and counts underflows and lock losses.
//   iCLK, iRST        : pixel clock, async active-high reset
//   iDISP_EN          : display enable; low blanks and unlocks
//   iCLR_STAT         : synchronous clear of both status counters
//   pix               : pixel stream (slave side)
//   oLCD_DE/HSD/VSD   : data enable, active-low syncs (registered)
//   oLCD_R/G/B        : pixel colour (registered)
//   oLOCKED           : lock FSM is in LOCKED
//   oUNDERFLOW_CNT    : saturating count of starved active pixels
//   oRESYNC_CNT       : saturating count of LOCKED->SEEK drops
module mtl2_lcd_timing_gen
  import mtl2_lcd_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iDISP_EN,
  input  logic                iCLR_STAT,
  mtl2_lcd_timing_gen_if.slave pix,
  output logic                oLCD_DE,
  output logic                oLCD_HSD,
  output logic                oLCD_VSD,
  output logic [7:0]          oLCD_R,
  output logic [7:0]          oLCD_G,
  output logic [7:0]          oLCD_B,
  output logic                oLOCKED,
  output logic [15:0]         oUNDERFLOW_CNT,
  output logic [15:0]         oRESYNC_CNT
);
  logic        active, hsync_n, vsync_n, origin;
  lock_state_e state;
  logic [23:0] rgb;
  logic        rdy, uf_inc, rs_inc;

  mtl2_raster_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_raster (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .active  (active),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n),
    .origin  (origin)
  );

  // SEEK drains non-SOF beats and holds an SOF beat at the head until the
  // origin. LOCKED takes exactly one beat per active pixel.
  always_comb begin
    rdy = 1'b0;
    if (!iRST && iDISP_EN) begin
      if (state == STATE_SEEK) rdy = pix.pix_valid && (!pix.pix_sof || origin);
      else                     rdy = active;
    end
  end
  assign pix.pix_ready = rdy;

  // An SOF off-origin or a non-SOF at origin means the stream and raster
  // disagree about frame boundaries.
  always_comb begin
    uf_inc = 1'b0;
    rs_inc = 1'b0;
    if (!iDISP_EN) begin
      rs_inc = (state == STATE_LOCKED);
    end else if (state == STATE_LOCKED && active) begin
      if (!pix.pix_valid)                   uf_inc = 1'b1;
      else if (pix.pix_sof != origin)       rs_inc = 1'b1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state          <= STATE_SEEK;
      oLCD_DE        <= 1'b0;
      oLCD_HSD       <= 1'b1;
      oLCD_VSD       <= 1'b1;
      rgb            <= '0;
      oUNDERFLOW_CNT <= '0;
      oRESYNC_CNT    <= '0;
    end else begin
      oLCD_HSD <= hsync_n;
      oLCD_VSD <= vsync_n;
      oLCD_DE  <= 1'b0;
      rgb      <= '0;
      if (!iDISP_EN) begin
        state <= STATE_SEEK;
      end else begin
        case (state)
          STATE_SEEK: begin
            if (origin && pix.pix_valid && pix.pix_sof) begin
              state   <= STATE_LOCKED;
              oLCD_DE <= 1'b1;
              rgb     <= pix.pix_data;
            end
          end
          STATE_LOCKED: begin
            if (active) begin
              oLCD_DE <= 1'b1;  // starved or resync pixels show black, DE stays up
              if (pix.pix_valid && (pix.pix_sof == origin)) rgb <= pix.pix_data;
              if (rs_inc) state <= STATE_SEEK;
            end
          end
          default: state <= STATE_SEEK;
        endcase
      end
      if (iCLR_STAT)   oUNDERFLOW_CNT <= '0;
      else if (uf_inc) oUNDERFLOW_CNT <= sat_inc(oUNDERFLOW_CNT);
      if (iCLR_STAT)   oRESYNC_CNT    <= '0;
      else if (rs_inc) oRESYNC_CNT    <= sat_inc(oRESYNC_CNT);
    end
  end

  assign oLOCKED = (state == STATE_LOCKED);
  assign oLCD_R  = rgb[23:16];
  assign oLCD_G  = rgb[15:8];
  assign oLCD_B  = rgb[7:0];
endmodule

// File: tb/tb_mtl2_lcd_timing_gen.sv
// Scoreboard bench: each driven cycle pushes its expected registered
// outputs; a negedge monitor pops and compares whatever the DUT presents.
// Raster: H 8/2/2/2 (HT=14), V 4/1/1/1 (VT=7), 32 pixels/frame.
module tb_mtl2_lcd_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic disp_en = 1'b0;
  logic clr_stat = 1'b0;
  logic de, hsd, vsd, locked;
  logic [7:0] r, g, b;
  logic [15:0] uf_cnt, rs_cnt;

  mtl2_lcd_timing_gen_if pix();

  mtl2_lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .iCLK(clk), .iRST(rst), .iDISP_EN(disp_en), .iCLR_STAT(clr_stat),
    .pix(pix.slave),
    .oLCD_DE(de), .oLCD_HSD(hsd), .oLCD_VSD(vsd),
    .oLCD_R(r), .oLCD_G(g), .oLCD_B(b),
    .oLOCKED(locked), .oUNDERFLOW_CNT(uf_cnt), .oRESYNC_CNT(rs_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        de, hsd, vsd, locked;
    logic [23:0] rgb;
    logic [15:0] uf, rs;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int bh = 0, bv = 0;     // raster position the next posedge samples
  bit ml = 1'b0;          // expected lock
  int muf = 0, mrs = 0;   // expected counters
  int bi = 0;             // source beat index (32 per frame)

  // Monitor: outputs registered at posedge are compared at the next negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a = '{de: de, hsd: hsd, vsd: vsd, locked: locked, rgb: {r, g, b}, uf: uf_cnt, rs: rs_cnt};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL out t=%0t act de%b hs%b vs%b lk%b rgb%h uf%0d rs%0d req de%b hs%b vs%b lk%b rgb%h uf%0d rs%0d",
                 $time, a.de, a.hsd, a.vsd, a.locked, a.rgb, a.uf, a.rs,
                 e.de, e.hsd, e.vsd, e.locked, e.rgb, e.uf, e.rs);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  task automatic cyc(input bit en, input bit valid, input bit sof,
                     input logic [23:0] data, input bit clr, output bit rdy);
    exp_t e;
    bit act, org;
    act = (bh < 8) && (bv < 4);
    org = (bh == 0) && (bv == 0);
    e = '0;
    e.hsd = !(bh >= 10 && bh < 12);
    e.vsd = (bv != 5);
    rdy = 1'b0;
    if (!en) begin
      if (ml) mrs++;
      ml = 1'b0;
    end else if (!ml) begin
      rdy = valid && (!sof || org);
      if (org && valid && sof) begin
        ml = 1'b1; e.de = 1'b1; e.rgb = data;
      end
    end else if (act) begin
      rdy = 1'b1; e.de = 1'b1;
      if (!valid) muf++;
      else if (sof != org) begin mrs++; ml = 1'b0; end
      else e.rgb = data;
    end
    if (clr) begin muf = 0; mrs = 0; end
    e.locked = ml; e.uf = 16'(muf); e.rs = 16'(mrs);
    disp_en = en; clr_stat = clr;
    pix.pix_valid = valid; pix.pix_sof = sof; pix.pix_data = data;
    #1;
    chk("ready", {31'd0, pix.pix_ready}, {31'd0, rdy});
    @(posedge clk);
    exp_q.push_back(e);
    bh++;
    if (bh == 14) begin bh = 0; bv = (bv == 6) ? 0 : bv + 1; end
    #1;
  endtask

  // Source stream; a hole drops VALID at line 1, pixels 2..4 (source
  // skips those beats so the frame stays aligned).
  task automatic stream(input int n, input bit en, input int inj, input bit hole, input bit clr_in_hole);
    for (int i = 0; i < n; i++) begin
      bit rdy, in_hole, v, s, c;
      in_hole = hole && bv == 1 && bh >= 2 && bh < 5;
      v = !in_hole;
      s = (bi % 32 == 0) || (inj >= 0 && bi % 32 == inj);
      c = clr_in_hole && bv == 1 && bh == 4;
      cyc(en, v, s, {8'(bi / 32), 8'(bi % 32), 8'h5A}, c, rdy);
      if (rdy && (v || in_hole)) bi++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_de",  {31'd0, de}, 32'd0);
    chk("rst_hsd", {31'd0, hsd}, 32'd1);
    chk("rst_vsd", {31'd0, vsd}, 32'd1);
    chk("rst_rgb", {8'd0, r, g, b}, 32'd0);
    chk("rst_lock", {31'd0, locked}, 32'd0);
    chk("rst_uf", {16'd0, uf_cnt}, 32'd0);
    chk("rst_rs", {16'd0, rs_cnt}, 32'd0);
    chk("rst_ready", {31'd0, pix.pix_ready}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    bh = 0; bv = 0; ml = 1'b0; muf = 0; mrs = 0;
  endtask

  initial begin
    pix.pix_valid = 1'b0; pix.pix_sof = 1'b0; pix.pix_data = '0;
    do_reset();
    // idle raster: syncs only, DE low, READY low
    stream(0, 1'b1, -1, 1'b0, 1'b0);
    for (int i = 0; i < 98; i++) begin
      bit rdy;
      cyc(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, rdy);
    end
    // two clean locked frames starting at origin
    stream(196, 1'b1, -1, 1'b0, 1'b0);
    chk("lock_clean", {31'd0, locked}, 32'd1);
    chk("beats_2f", bi, 32'd64);
    // 3-cycle starvation mid-line
    stream(98, 1'b1, -1, 1'b1, 1'b0);
    chk("uf_3", {16'd0, uf_cnt}, 32'd3);
    chk("lock_uf", {31'd0, locked}, 32'd1);
    // stray SOF on beat 5, drain, relock next frame
    stream(98, 1'b1, 5, 1'b0, 1'b0);
    chk("rs_inj", {16'd0, rs_cnt}, 32'd1);
    stream(98, 1'b1, -1, 1'b0, 1'b0);
    chk("relock_inj", {31'd0, locked}, 32'd1);
    // display off for >1 frame, then stream resumes mid-frame
    stream(118, 1'b0, -1, 1'b0, 1'b0);
    chk("rs_en", {16'd0, rs_cnt}, 32'd2);
    chk("unlock_en", {31'd0, locked}, 32'd0);
    bi = 32 * 10 + 10;
    stream(176, 1'b1, -1, 1'b0, 1'b0);
    chk("relock_mid", {31'd0, locked}, 32'd1);
    // reset mid-line, relock with fresh SOF at origin
    stream(40, 1'b1, -1, 1'b0, 1'b0);
    do_reset();
    bi = 0;
    stream(98, 1'b1, -1, 1'b1, 1'b0);
    chk("uf_after_rst", {16'd0, uf_cnt}, 32'd3);
    // clear wins over a same-cycle underflow
    stream(98, 1'b1, -1, 1'b1, 1'b1);
    chk("uf_clr", {16'd0, uf_cnt}, 32'd0);
    chk("rs_clr", {16'd0, rs_cnt}, 32'd0);
    @(negedge clk);
    #1;
    chk("q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
